datapath_reg_bank: RTL and testbench
====================================

// Module: datapath_reg_bank
// PURPOSE
//  Register bank and status register directly upstream of function_unit.
//  - Drives busA and busB; busB can be a constant instead of a register.
//  - Accepts the function_unit result F plus V/C/N/Z through a one-stage writeback register.
//  - Holds the flags for later branch logic.
//  - Reads are combinational; writes commit one cycle after capture, with forwarding to cover that gap.
// PARAMETERS
//  DATA_W   32  datapath width; matches function_unit busA/busB/F
//  ADDR_W   5   register address width; depth is 2**ADDR_W (32 regs)
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       asynchronous reset, active-high
//  a_sel     in   ADDR_W  register address driven onto busA
//  b_sel     in   ADDR_W  register address driven onto busB when mb=0
//  mb        in   1       1: busB = const_in; 0: busB = R[b_sel]
//  const_in  in   DATA_W  immediate constant for busB
//  busA      out  DATA_W  operand A to function_unit
//  busB      out  DATA_W  operand B to function_unit
//  wr_en     in   1       capture f_in for writeback this cycle
//  wr_addr   in   ADDR_W  destination register of f_in
//  f_in      in   DATA_W  function_unit result F
//  flag_ld   in   1       latch v_in/c_in/n_in/z_in this cycle
//  v_in,c_in,n_in,z_in  in  1 each  function_unit status flags
//  flags     out  4       registered {V,C,N,Z}
//  wb_pend   out  1       writeback register holds an uncommitted write
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All registers, wb data/addr/valid and flags clear to 0.
//   - busA=busB=0 unless mb=1 (then busB=const_in); wb_pend=0.
//   - Reset mid-writeback discards the pending write.
//  R0 is hardwired 0:
//   - Reads of address 0 always return 0.
//   - Writes to address 0 are dropped at capture: wb_valid is not set.
//  Writeback pipeline:
//   - Edge n: if wr_en && wr_addr!=0, then wb_data<=f_in, wb_addr<=wr_addr, wb_valid<=1; else wb_valid<=0.
//   - Edge n+1: if wb_valid, R[wb_addr]<=wb_data.
//   - Result: write latency is 2 edges; wb_pend=wb_valid.
//  Reads (combinational):
//   - busA = (a_sel==0) ? 0 : (wb_valid && wb_addr==a_sel) ? wb_data : R[a_sel].
//   - busB follows the same rule with b_sel, unless mb=1.
//   - f_in is NEVER forwarded combinationally; doing so would create a loop through function_unit.
//  Back-to-back writes:
//   - The new capture overwrites the wb register on the same edge the old value commits.
//   - Same address in both writes: the newer value wins and is visible via forwarding.
//  Flags:
//   - flags<={v_in,c_in,n_in,z_in} on the edge when flag_ld=1; hold otherwise.
//   - Independent of wr_en.
//  Address wrap: none; every ADDR_W code is a valid register.
//  No X propagation: no output depends on uninitialised storage after reset.
// STRUCTURE
//  Shared package datapath_pkg:
//   - DATA_W/ADDR_W defaults.
//   - Flag bit index constants FLAG_V=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0.
//   - Must match the function_unit flag order.
//  One sub-module, regbank_read_port:
//   - Zero check, forwarding compare and array mux.
//   - Instantiated twice (A, and B before the mb mux).
//  Array, wb register and flag register live in the top.
// TESTING
//  1 Reset: assert rst mid-cycle with wb_valid=1 -> busA=busB=0, flags=0, wb_pend=0 immediately; after release R[wr_addr] still 0.
//  2 Write/forward: wr_en, wr_addr=1, f_in=5; next cycle a_sel=1 -> busA=5 with wb_pend=1; cycle after -> busA=5 from array, wb_pend=0.
//  3 Constant mux: R2=3, b_sel=2 -> busB=3; mb=1, const_in=32'hFFFF_FFFF -> busB=FFFF_FFFF.
//  4 R0: wr_en, wr_addr=0, f_in=32'hDEAD_BEEF -> wb_pend stays 0; a_sel=0 -> busA=0.
//  5 Back-to-back same address: write R3=7 then R3=9 on consecutive edges -> a_sel=3 reads 7 then 9; settles at 9.
//  6 Flags: flag_ld=1, {V,C,N,Z}=1010 -> flags=4'b1010 next edge; flag_ld=0 with inputs 0101 -> flags hold 1010.
//  Closed-loop check: bench drives busA/busB into function_unit; FS=00010, R1=5, R2=3 -> write back F=8; FS=00101 -> F=2, C=1, Z=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath constants: default widths and the {V,C,N,Z} flag bit order
// that the register bank and function_unit both rely on.
package datapath_pkg;
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;
   localparam int FLAG_W = 4;

   // Bit positions inside the flags vector; function_unit uses the same order.
   localparam int FLAG_V = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   function automatic logic [FLAG_W-1:0] packFlags(input logic v, input logic c,
                                                   input logic n, input logic z);
      logic [FLAG_W-1:0] f;
      f         = '0;
      f[FLAG_V] = v;
      f[FLAG_C] = c;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      return f;
   endfunction
endpackage

// File: rtl/datapath_reg_bank_if.sv
// Operand, writeback and status signals between the datapath controller
// (master) and the register bank (slave).
interface datapath_reg_bank_if
   import datapath_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
);
   logic [ADDR_W-1:0] a_sel;
   logic [ADDR_W-1:0] b_sel;
   logic              mb;
   logic [DATA_W-1:0] const_in;
   logic [DATA_W-1:0] busA;
   logic [DATA_W-1:0] busB;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] f_in;
   logic              flag_ld;
   logic              v_in;
   logic              c_in;
   logic              n_in;
   logic              z_in;
   logic [FLAG_W-1:0] flags;
   logic              wb_pend;

   modport master (
      output a_sel, b_sel, mb, const_in, wr_en, wr_addr, f_in,
             flag_ld, v_in, c_in, n_in, z_in,
      input  busA, busB, flags, wb_pend
   );

   modport slave (
      input  a_sel, b_sel, mb, const_in, wr_en, wr_addr, f_in,
             flag_ld, v_in, c_in, n_in, z_in,
      output busA, busB, flags, wb_pend
   );
endinterface

// File: rtl/regbank_read_port.sv
// One combinational read port: R0 reads as zero, a pending writeback is
// forwarded ahead of the array, otherwise the addressed register is returned.
module regbank_read_port
   import datapath_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic [ADDR_W-1:0]                  sel,
   input  logic                               wbValid,
   input  logic [ADDR_W-1:0]                  wbAddr,
   input  logic [DATA_W-1:0]                  wbData,
   input  logic [2**ADDR_W-1:0][DATA_W-1:0]   regs,
   output logic [DATA_W-1:0]                  rdData
);
   always_comb begin
      rdData = regs[sel];
      if (sel == '0) begin
         rdData = '0;
      end else if (wbValid && (wbAddr == sel)) begin
         rdData = wbData;
      end
   end
endmodule

// File: rtl/datapath_reg_bank.sv
// Register bank with a one-stage writeback register and forwarding, plus the
// {V,C,N,Z} status register feeding later branch logic.
module datapath_reg_bank
   import datapath_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   datapath_reg_bank_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic                         wbValidReg;
   logic [ADDR_W-1:0]            wbAddrReg;
   logic [DATA_W-1:0]            wbDataReg;
   logic [FLAG_W-1:0]            flagsReg;
   logic [DATA_W-1:0]            portAData;
   logic [DATA_W-1:0]            portBData;
   logic                         captureWr;

   // Writes to R0 never enter the pipeline, so wb_pend stays low for them.
   assign captureWr = bus.wr_en && (bus.wr_addr != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbValidReg <= 1'b0;
         wbAddrReg  <= '0;
         wbDataReg  <= '0;
      end else begin
         wbValidReg <= captureWr;
         if (captureWr) begin
            wbAddrReg <= bus.wr_addr;
            wbDataReg <= bus.f_in;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign regs[gi] = '0;
         end else begin : g_store
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  regs[gi] <= '0;
               end else if (wbValidReg && (wbAddrReg == ADDR_W'(gi))) begin
                  regs[gi] <= wbDataReg;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flagsReg <= '0;
      end else if (bus.flag_ld) begin
         flagsReg <= packFlags(bus.v_in, bus.c_in, bus.n_in, bus.z_in);
      end
   end

   // f_in is deliberately not forwarded: it would close a loop through function_unit.
   regbank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_portA (
      .sel     (bus.a_sel),
      .wbValid (wbValidReg),
      .wbAddr  (wbAddrReg),
      .wbData  (wbDataReg),
      .regs    (regs),
      .rdData  (portAData)
   );

   regbank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_portB (
      .sel     (bus.b_sel),
      .wbValid (wbValidReg),
      .wbAddr  (wbAddrReg),
      .wbData  (wbDataReg),
      .regs    (regs),
      .rdData  (portBData)
   );

   assign bus.busA    = portAData;
   assign bus.busB    = bus.mb ? bus.const_in : portBData;
   assign bus.flags   = flagsReg;
   assign bus.wb_pend = wbValidReg;
endmodule

// File: tb/tb_datapath_reg_bank.sv
// Scenario bench for datapath_reg_bank, including a small function_unit model
// that closes the loop busA/busB -> F -> writeback.
module tb_datapath_reg_bank;
   logic clk;
   logic rst;

   datapath_reg_bank_if bus ();

   datapath_reg_bank dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;
   logic [31:0] expQ[$];
   logic [31:0] expV;

   // Direct stimulus or function_unit model drives f_in and the flag inputs.
   logic        useFu;
   logic [31:0] tbF;
   logic [3:0]  tbFlags;
   logic [4:0]  fs;
   logic [31:0] bTerm;
   logic [32:0] fuSum;
   logic [31:0] fuF;
   logic [3:0]  fuFlags;

   always_comb begin
      case (fs[2:1])
         2'b00:   bTerm = 32'h0;
         2'b01:   bTerm = bus.busB;
         2'b10:   bTerm = ~bus.busB;
         default: bTerm = 32'hFFFF_FFFF;
      endcase
      fuSum      = {1'b0, bus.busA} + {1'b0, bTerm} + {32'h0, fs[0]};
      fuF        = fuSum[31:0];
      fuFlags[3] = (bus.busA[31] == bTerm[31]) && (fuF[31] != bus.busA[31]);
      fuFlags[2] = fuSum[32];
      fuFlags[1] = fuF[31];
      fuFlags[0] = (fuF == 32'h0);
   end

   always_comb begin
      bus.f_in = useFu ? fuF : tbF;
      {bus.v_in, bus.c_in, bus.n_in, bus.z_in} = useFu ? fuFlags : tbFlags;
   end

   task automatic stepEdge();
      @(posedge clk);
      #1;
      $display("[%0t] edge wr_en=%0b wr_addr=%0d a_sel=%0d b_sel=%0d mb=%0b busA=%h busB=%h flags=%b wb_pend=%0b",
               $time, bus.wr_en, bus.wr_addr, bus.a_sel, bus.b_sel, bus.mb,
               bus.busA, bus.busB, bus.flags, bus.wb_pend);
   endtask

   task automatic test_reset();
      bus.mb = 1'b1; bus.const_in = 32'h0000_00A5;
      #2;
      checks++;
      if (bus.busA !== 32'h0 || bus.flags !== 4'h0 || bus.wb_pend !== 1'b0) begin
         errors++;
         $display("FAIL por_state busA=%h flags=%b wb_pend=%b required 0/0/0", bus.busA, bus.flags, bus.wb_pend);
      end
      checks++;
      if (bus.busB !== 32'h0000_00A5) begin
         errors++;
         $display("FAIL por_busB_const got=%h required=000000a5", bus.busB);
      end
      @(negedge clk); rst = 1'b0; bus.mb = 1'b0;
      stepEdge();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd4; tbF = 32'h55; bus.flag_ld = 1'b1; tbFlags = 4'b1111;
      stepEdge();
      bus.wr_en = 1'b0; bus.flag_ld = 1'b0; bus.a_sel = 5'd4; bus.b_sel = 5'd4;
      #1;
      checks++;
      if (bus.wb_pend !== 1'b1 || bus.busA !== 32'h55 || bus.flags !== 4'b1111) begin
         errors++;
         $display("FAIL pre_reset wb_pend=%b busA=%h flags=%b required 1/00000055/1111", bus.wb_pend, bus.busA, bus.flags);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.busA !== 32'h0 || bus.busB !== 32'h0 || bus.flags !== 4'h0 || bus.wb_pend !== 1'b0) begin
         errors++;
         $display("FAIL async_reset busA=%h busB=%h flags=%b wb_pend=%b required all 0", bus.busA, bus.busB, bus.flags, bus.wb_pend);
      end
      @(negedge clk); rst = 1'b0;
      stepEdge();
      stepEdge();
      checks++;
      if (bus.busA !== 32'h0) begin
         errors++;
         $display("FAIL reset_discard R4=%h required=00000000", bus.busA);
      end
   endtask

   task automatic test_write_forward();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd1; tbF = 32'd5;
      expQ.push_back(32'd5);
      expQ.push_back(32'd5);
      stepEdge();
      bus.wr_en = 1'b0; bus.a_sel = 5'd1;
      @(negedge clk);
      expV = expQ.pop_front();
      checks++;
      if (bus.busA !== expV || bus.wb_pend !== 1'b1) begin
         errors++;
         $display("FAIL forward busA=%h wb_pend=%b required %h/1", bus.busA, bus.wb_pend, expV);
      end
      stepEdge();
      expV = expQ.pop_front();
      checks++;
      if (bus.busA !== expV || bus.wb_pend !== 1'b0) begin
         errors++;
         $display("FAIL array_read busA=%h wb_pend=%b required %h/0", bus.busA, bus.wb_pend, expV);
      end
   endtask

   task automatic test_const_mux();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd2; tbF = 32'd3;
      stepEdge();
      bus.wr_en = 1'b0;
      stepEdge();
      bus.b_sel = 5'd2; bus.mb = 1'b0;
      #1;
      checks++;
      if (bus.busB !== 32'd3) begin
         errors++;
         $display("FAIL busB_reg got=%h required=00000003", bus.busB);
      end
      bus.mb = 1'b1; bus.const_in = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (bus.busB !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL busB_const got=%h required=ffffffff", bus.busB);
      end
      bus.mb = 1'b0;
   endtask

   task automatic test_r0();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd0; tbF = 32'hDEAD_BEEF;
      stepEdge();
      bus.wr_en = 1'b0; bus.a_sel = 5'd0; bus.b_sel = 5'd0;
      #1;
      checks++;
      if (bus.wb_pend !== 1'b0 || bus.busA !== 32'h0) begin
         errors++;
         $display("FAIL r0_capture wb_pend=%b busA=%h required 0/00000000", bus.wb_pend, bus.busA);
      end
      stepEdge();
      checks++;
      if (bus.busA !== 32'h0 || bus.busB !== 32'h0) begin
         errors++;
         $display("FAIL r0_read busA=%h busB=%h required 0/0", bus.busA, bus.busB);
      end
   endtask

   task automatic test_back_to_back();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; tbF = 32'd7;
      expQ.push_back(32'd7);
      stepEdge();
      tbF = 32'd9; bus.a_sel = 5'd3;
      expQ.push_back(32'd9);
      expQ.push_back(32'd9);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expV = expQ.pop_front();
         checks++;
         if (bus.busA !== expV || bus.wb_pend !== (i < 2)) begin
            errors++;
            $display("FAIL b2b_step%0d busA=%h wb_pend=%b required %h/%0b", i, bus.busA, bus.wb_pend, expV, (i < 2));
         end
         stepEdge();
         bus.wr_en = 1'b0;
      end
   endtask

   task automatic test_flags();
      bus.flag_ld = 1'b1; tbFlags = 4'b1010;
      bus.wr_en = 1'b0;
      stepEdge();
      bus.flag_ld = 1'b0; tbFlags = 4'b0101;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd7; tbF = 32'h1;
      @(negedge clk);
      checks++;
      if (bus.flags !== 4'b1010) begin
         errors++;
         $display("FAIL flags_load got=%b required=1010", bus.flags);
      end
      stepEdge();
      bus.wr_en = 1'b0;
      checks++;
      if (bus.flags !== 4'b1010) begin
         errors++;
         $display("FAIL flags_hold got=%b required=1010", bus.flags);
      end
   endtask

   task automatic test_closed_loop();
      useFu = 1'b1; fs = 5'b00010;
      bus.a_sel = 5'd1; bus.b_sel = 5'd2; bus.mb = 1'b0;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd5;
      expQ.push_back(32'd8);
      stepEdge();
      bus.wr_en = 1'b0;
      stepEdge();
      bus.a_sel = 5'd5;
      @(negedge clk);
      expV = expQ.pop_front();
      checks++;
      if (bus.busA !== expV) begin
         errors++;
         $display("FAIL loop_add R5=%h required=%h", bus.busA, expV);
      end
      stepEdge();
      bus.a_sel = 5'd1; fs = 5'b00101;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.flag_ld = 1'b1;
      expQ.push_back(32'd2);
      stepEdge();
      bus.wr_en = 1'b0; bus.flag_ld = 1'b0;
      checks++;
      if (bus.flags !== 4'b0100) begin
         errors++;
         $display("FAIL loop_sub_flags got=%b required=0100", bus.flags);
      end
      stepEdge();
      bus.a_sel = 5'd6;
      @(negedge clk);
      expV = expQ.pop_front();
      checks++;
      if (bus.busA !== expV || bus.wb_pend !== 1'b0) begin
         errors++;
         $display("FAIL loop_sub R6=%h wb_pend=%b required %h/0", bus.busA, bus.wb_pend, expV);
      end
      useFu = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      useFu = 1'b0; tbF = '0; tbFlags = '0; fs = '0;
      bus.a_sel = '0; bus.b_sel = '0; bus.mb = 1'b0; bus.const_in = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.flag_ld = 1'b0;
      test_reset();
      test_write_forward();
      test_const_mux();
      test_r0();
      test_back_to_back();
      test_flags();
      test_closed_loop();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d required=0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
